// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types, constants and helpers for the programmable instruction memory
// Defines the load-state encoding, the NOP fetch word and an even-parity helper.
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } imem_state_t;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  // Callers zero-extend narrower words; zeros do not change the parity.
  function automatic logic even_parity(input logic [63:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/imem_load_ctrl.sv
// rtl/imem_load_ctrl.sv - load-port FSM and word counter for imem_prog
// Turns prog_start/valid/last beats into RAM write strobes and the done flag.
module imem_load_ctrl
  import imem_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_prog_start,
  input  logic                       i_prog_valid,
  input  logic                       i_prog_last,
  output logic                       o_wr_en,
  output logic [$clog2(DEPTH)-1:0]   o_wr_idx,
  output logic                       o_prog_ready,
  output logic                       o_prog_done,
  output logic [$clog2(DEPTH):0]     o_prog_count
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  imem_state_t    r_state;
  imem_state_t    w_state_nxt;
  logic [CW-1:0]  r_count;
  logic [CW-1:0]  w_count_nxt;
  logic           w_beat;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_beat      = (r_state == LOAD) && i_prog_valid;
    case (r_state)
      IDLE, DONE: begin
        if (i_prog_start) begin
          w_state_nxt = LOAD;
          w_count_nxt = '0;
        end
      end
      LOAD: begin
        // A restart wins over prog_last; a coincident beat becomes word 0.
        if (i_prog_start) begin
          w_count_nxt = w_beat ? CW'(1) : '0;
        end else if (w_beat) begin
          w_count_nxt = r_count + CW'(1);
          if (i_prog_last || (r_count == CW'(DEPTH - 1))) begin
            w_state_nxt = DONE;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_count_nxt = '0;
      end
    endcase
  end

  assign o_wr_en      = w_beat;
  assign o_wr_idx     = i_prog_start ? '0 : r_count[IW-1:0];
  assign o_prog_ready = (r_state == LOAD);
  assign o_prog_done  = (r_state == DONE);
  assign o_prog_count = r_count;

endmodule

// File: rtl/imem_prog.sv
// rtl/imem_prog.sv - instruction memory with combinational fetch and a streamed programming port
// Optional stored-word parity is enabled by defining IMEM_PARITY_EN.
module imem_prog
  import imem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  localparam int ADDR_W = $clog2(DEPTH) + 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ADDR_W-1:0]         addr,
  output logic [DATA_W-1:0]         read_data,
  output logic                      addr_err,
  output logic                      parity_err,
  input  logic                      prog_start,
  input  logic                      prog_valid,
  input  logic                      prog_last,
  input  logic [DATA_W-1:0]         prog_data,
  output logic                      prog_ready,
  output logic                      prog_done,
  output logic [$clog2(DEPTH):0]    prog_count
);

  localparam int IW = $clog2(DEPTH);
`ifdef IMEM_PARITY_EN
  localparam int RW = DATA_W + 1;
`else
  localparam int RW = DATA_W;
`endif

  logic [RW-1:0]  r_mem [DEPTH];
  logic           w_wr_en;
  logic [IW-1:0]  w_wr_idx;
  logic [IW-1:0]  w_rd_idx;
  logic [RW-1:0]  w_wr_word;
  logic [RW-1:0]  w_rd_word;

  imem_load_ctrl #(
    .DEPTH(DEPTH)
  ) u_load_ctrl (
    .clk          (clk),
    .reset        (reset),
    .i_prog_start (prog_start),
    .i_prog_valid (prog_valid),
    .i_prog_last  (prog_last),
    .o_wr_en      (w_wr_en),
    .o_wr_idx     (w_wr_idx),
    .o_prog_ready (prog_ready),
    .o_prog_done  (prog_done),
    .o_prog_count (prog_count)
  );

`ifdef IMEM_PARITY_EN
  assign w_wr_word = {even_parity(64'(prog_data)), prog_data};
`else
  assign w_wr_word = prog_data;
`endif

  // RAM is deliberately not reset so a partial load survives a core reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_wr_idx] <= w_wr_word;
    end
  end

  assign w_rd_idx  = addr[ADDR_W-1:2];
  assign w_rd_word = r_mem[w_rd_idx];
  assign read_data = prog_done ? w_rd_word[DATA_W-1:0] : DATA_W'(NOP_WORD);
  assign addr_err  = (addr[1:0] != 2'b00);

`ifdef IMEM_PARITY_EN
  assign parity_err = prog_done && (^w_rd_word);
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_prog.sv
// tb/tb_imem_prog.sv - scoreboard bench for imem_prog
// Expected words are queued as beats are driven and popped when fetched back.
module tb_imem_prog;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = $clog2(DEPTH) + 2;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [ADDR_W-1:0]      addr;
  logic [DATA_W-1:0]      read_data;
  logic                   addr_err;
  logic                   parity_err;
  logic                   prog_start;
  logic                   prog_valid;
  logic                   prog_last;
  logic [DATA_W-1:0]      prog_data;
  logic                   prog_ready;
  logic                   prog_done;
  logic [$clog2(DEPTH):0] prog_count;

  int n_checks = 0;
  int n_pass   = 0;
  logic [DATA_W-1:0] sb_q[$];

  imem_prog #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .addr       (addr),
    .read_data  (read_data),
    .addr_err   (addr_err),
    .parity_err (parity_err),
    .prog_start (prog_start),
    .prog_valid (prog_valid),
    .prog_last  (prog_last),
    .prog_data  (prog_data),
    .prog_ready (prog_ready),
    .prog_done  (prog_done),
    .prog_count (prog_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Drive one cycle of inputs from a negedge; returns at the following negedge.
  task automatic cycle(input logic st, input logic vl, input logic ls, input logic [DATA_W-1:0] d);
    prog_start = st;
    prog_valid = vl;
    prog_last  = ls;
    prog_data  = d;
    @(posedge clk);
    @(negedge clk);
    prog_start = 1'b0;
    prog_valid = 1'b0;
    prog_last  = 1'b0;
  endtask

  task automatic start_load();
    sb_q.delete();
    cycle(1'b1, 1'b0, 1'b0, '0);
    check("ready_after_start", 64'(prog_ready), 64'd1);
  endtask

  task automatic beat(input logic [DATA_W-1:0] d, input logic ls);
    sb_q.push_back(d);
    cycle(1'b0, 1'b1, ls, d);
  endtask

  // Fetch back every queued word from index 0 upward.
  task automatic drain(input string tag);
    int idx = 0;
    while (sb_q.size() > 0) begin
      logic [DATA_W-1:0] e;
      e = sb_q.pop_front();
      addr = ADDR_W'(idx * 4);
      #1;
      check(tag, 64'(read_data), 64'(e));
      idx++;
    end
  endtask

  initial begin
    int exp_cnt;
    reset = 1'b1;
    addr = '0;
    prog_start = 1'b0;
    prog_valid = 1'b0;
    prog_last  = 1'b0;
    prog_data  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // 1: reset state
    addr = 8'h10;
    #1;
    check("rst_read_data", 64'(read_data), 64'h0);
    check("rst_done", 64'(prog_done), 64'd0);
    check("rst_ready", 64'(prog_ready), 64'd0);
    check("rst_addr_err", 64'(addr_err), 64'd0);
    check("rst_count", 64'(prog_count), 64'd0);
    cycle(1'b0, 1'b1, 1'b1, 32'h1111_1111);
    check("idle_valid_ignored", 64'(prog_ready), 64'd0);

    // 2: short load ending on prog_last
    start_load();
    beat(32'h2008_0005, 1'b0);
    beat(32'h2009_000C, 1'b0);
    check("t2_not_done_yet", 64'(prog_done), 64'd0);
    beat(32'hAC09_0054, 1'b1);
    check("t2_done", 64'(prog_done), 64'd1);
    check("t2_count", 64'(prog_count), 64'd3);
    addr = 8'h08;
    #1;
    check("t2_word2", 64'(read_data), 64'hAC09_0054);
    drain("t2_fetch");

    // 3: full-depth load with no prog_last
    start_load();
    for (int i = 0; i < DEPTH; i++) beat($urandom(), 1'b0);
    check("t3_done", 64'(prog_done), 64'd1);
    check("t3_count", 64'(prog_count), 64'd64);
    check("t3_ready", 64'(prog_ready), 64'd0);
    addr = 8'hFC;
    #1;
    check("t3_word63", 64'(read_data), 64'(sb_q[DEPTH-1]));
    cycle(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF);
    check("t3_extra_count", 64'(prog_count), 64'd64);
    drain("t3_fetch");

    // 4: gapped valid
    start_load();
    exp_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) begin
        beat(32'hC0DE_0000 | DATA_W'(i), i == 6);
        exp_cnt++;
      end else begin
        cycle(1'b0, 1'b0, 1'b1, 32'hBAD0_0000);
      end
      check("t4_count", 64'(prog_count), 64'(exp_cnt));
      if (i == 6) break;
    end
    check("t4_done", 64'(prog_done), 64'd1);
    drain("t4_fetch");

    // 5: restart mid-load with coincident beat, prog_last loses to start
    start_load();
    beat(32'hAAAA_0001, 1'b0);
    beat(32'hAAAA_0002, 1'b0);
    sb_q.delete();
    sb_q.push_back(32'hDEAD_BEEF);
    cycle(1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF);
    check("t5_restart_count", 64'(prog_count), 64'd1);
    check("t5_still_load", 64'(prog_ready), 64'd1);
    check("t5_not_done", 64'(prog_done), 64'd0);
    beat(32'h1234_5678, 1'b1);
    check("t5_done", 64'(prog_done), 64'd1);
    check("t5_count", 64'(prog_count), 64'd2);
    drain("t5_fetch");

    start_load();
    beat(32'h5555_AAAA, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    addr = 8'h00;
    #1;
    check("t5_rst_done", 64'(prog_done), 64'd0);
    check("t5_rst_ready", 64'(prog_ready), 64'd0);
    check("t5_rst_count", 64'(prog_count), 64'd0);
    check("t5_rst_read", 64'(read_data), 64'h0);

    // 6: misaligned fetch and parity
    start_load();
    beat(32'h0F0F_0001, 1'b0);
    beat(32'h0F0F_0002, 1'b1);
    addr = 8'h06;
    #1;
    check("t6_addr_err", 64'(addr_err), 64'd1);
    check("t6_misalign_read", 64'(read_data), 64'h0F0F_0002);
    check("t6_parity_err", 64'(parity_err), 64'd0);
    addr = 8'h04;
    #1;
    check("t6_aligned", 64'(addr_err), 64'd0);
    drain("t6_fetch");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
